// File: rtl/clk_tick_gen.sv
// clk_tick_gen: qualifies PLL lock, drives the peripheral reset and produces
// single-cycle clock-enable ticks (UART oversample, SPI edge, 1 ms) from CLK_FREQ_HZ.
module clk_tick_gen #(
   parameter int unsigned CLK_FREQ_HZ        = 66_000_000,
   parameter int unsigned UART_BAUD          = 115_200,
   parameter int unsigned UART_OVERSAMPLE    = 16,
   parameter int unsigned SPI_SCLK_HZ        = 1_000_000,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned USE_LOCK           = 1
) (
   input  logic i_sys_clk,
   input  logic i_reset,
   input  logic i_pll_lock,
   output logic o_ready,
   output logic o_periph_rst,
   output logic o_uart_tick,
   output logic o_spi_tick,
   output logic o_ms_tick
);

   localparam int unsigned SPI_DIV  = CLK_FREQ_HZ / (2 * SPI_SCLK_HZ);
   localparam int unsigned MS_DIV   = CLK_FREQ_HZ / 1000;
   localparam int unsigned UART_INC = UART_BAUD * UART_OVERSAMPLE;

   localparam int unsigned SPI_W  = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
   localparam int unsigned MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam int unsigned STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int unsigned ACC_W  = $clog2(CLK_FREQ_HZ) + 1;

   localparam logic [SPI_W-1:0]  SPI_LAST  = SPI_W'(SPI_DIV - 1);
   localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(MS_DIV - 1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [ACC_W:0]    INC_EXT   = (ACC_W + 1)'(UART_INC);
   localparam logic [ACC_W:0]    FREQ_EXT  = (ACC_W + 1)'(CLK_FREQ_HZ);

   if (SPI_DIV < 1) begin : g_err_spi_div
      $error("clk_tick_gen: SPI_DIV must be at least 1");
   end
   if (MS_DIV < 1) begin : g_err_ms_div
      $error("clk_tick_gen: MS_DIV must be at least 1");
   end
   if (UART_INC >= CLK_FREQ_HZ) begin : g_err_uart_inc
      $error("clk_tick_gen: UART_BAUD*UART_OVERSAMPLE must be below CLK_FREQ_HZ");
   end

   typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;

   state_t            state;
   logic [1:0]        lock_sync;
   logic              lock_s;
   logic [STAB_W-1:0] stab_cnt;
   logic              run_next;
   logic [SPI_W-1:0]  spi_cnt;
   logic [MS_W-1:0]   ms_cnt;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W:0]    acc_sum;

   always_ff @(posedge i_sys_clk) begin
      if (i_reset) lock_sync <= '0;
      else         lock_sync <= {lock_sync[0], i_pll_lock};
   end

   assign lock_s = (USE_LOCK != 0) ? lock_sync[1] : 1'b1;

   // Next cycle is a RUN cycle; ticks and o_ready are registered against this
   // so they line up with the state they describe.
   always_comb begin
      run_next = 1'b0;
      if (lock_s) begin
         run_next = (state == RUN) || ((state == STABLE) && (stab_cnt == STAB_LAST));
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         state        <= WAIT_LOCK;
         stab_cnt     <= '0;
         o_ready      <= 1'b0;
         o_periph_rst <= 1'b1;
      end else begin
         o_ready      <= run_next;
         o_periph_rst <= ~run_next;
         unique case (state)
            WAIT_LOCK: begin
               if (lock_s) begin
                  state    <= STABLE;
                  stab_cnt <= '0;
               end
            end
            STABLE: begin
               if (!lock_s)                    state    <= WAIT_LOCK;
               else if (stab_cnt == STAB_LAST) state    <= RUN;
               else                            stab_cnt <= stab_cnt + 1'b1;
            end
            RUN: begin
               if (!lock_s) state <= WAIT_LOCK;
            end
            default: state <= WAIT_LOCK;
         endcase
      end
   end

   assign acc_sum = {1'b0, acc} + INC_EXT;

   always_ff @(posedge i_sys_clk) begin
      if (i_reset || !run_next) begin
         spi_cnt     <= '0;
         ms_cnt      <= '0;
         acc         <= '0;
         o_spi_tick  <= 1'b0;
         o_ms_tick   <= 1'b0;
         o_uart_tick <= 1'b0;
      end else begin
         if (spi_cnt == SPI_LAST) begin
            spi_cnt    <= '0;
            o_spi_tick <= 1'b1;
         end else begin
            spi_cnt    <= spi_cnt + 1'b1;
            o_spi_tick <= 1'b0;
         end
         if (ms_cnt == MS_LAST) begin
            ms_cnt    <= '0;
            o_ms_tick <= 1'b1;
         end else begin
            ms_cnt    <= ms_cnt + 1'b1;
            o_ms_tick <= 1'b0;
         end
         if (acc_sum >= FREQ_EXT) begin
            acc         <= ACC_W'(acc_sum - FREQ_EXT);
            o_uart_tick <= 1'b1;
         end else begin
            acc         <= ACC_W'(acc_sum);
            o_uart_tick <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Bench for clk_tick_gen: a cycle-level reference model queues expected outputs,
// a monitor pops and compares them; two instances cover USE_LOCK=1 and USE_LOCK=0.
module tb_clk_tick_gen;

   localparam int unsigned F       = 660_000;
   localparam int unsigned BAUD    = 1152;
   localparam int unsigned OVS     = 16;
   localparam int unsigned SCLK    = 10_000;
   localparam int unsigned L       = 1024;
   localparam longint      SPI_DIV = F / (2 * SCLK);
   localparam longint      MS_DIV  = F / 1000;
   localparam longint      INC     = BAUD * OVS;
   localparam longint      GAP_LO  = F / INC;
   localparam longint      GAP_HI  = GAP_LO + 1;

   logic clk = 1'b0;
   logic rst;
   logic lock;
   logic rdy_a, prst_a, uart_a, spi_a, ms_a;
   logic rdy_b, prst_b, uart_b, spi_b, ms_b;
   logic [4:0] ov [2];

   always #5 clk = ~clk;

   clk_tick_gen #(
      .CLK_FREQ_HZ(F), .UART_BAUD(BAUD), .UART_OVERSAMPLE(OVS),
      .SPI_SCLK_HZ(SCLK), .LOCK_STABLE_CYCLES(L), .USE_LOCK(1)
   ) dut_a (
      .i_sys_clk(clk), .i_reset(rst), .i_pll_lock(lock),
      .o_ready(rdy_a), .o_periph_rst(prst_a), .o_uart_tick(uart_a),
      .o_spi_tick(spi_a), .o_ms_tick(ms_a)
   );

   clk_tick_gen #(
      .CLK_FREQ_HZ(F), .UART_BAUD(BAUD), .UART_OVERSAMPLE(OVS),
      .SPI_SCLK_HZ(SCLK), .LOCK_STABLE_CYCLES(L), .USE_LOCK(0)
   ) dut_b (
      .i_sys_clk(clk), .i_reset(rst), .i_pll_lock(1'b0),
      .o_ready(rdy_b), .o_periph_rst(prst_b), .o_uart_tick(uart_b),
      .o_spi_tick(spi_b), .o_ms_tick(ms_b)
   );

   assign ov[0] = {rdy_a, prst_a, uart_a, spi_a, ms_a};
   assign ov[1] = {rdy_b, prst_b, uart_b, spi_b, ms_b};

   typedef struct {
      string  nm;
      longint act;
      longint exp;
   } req_t;

   int     checks   = 0;
   int     failures = 0;
   longint cyc      = 0;
   req_t   cq [$];
   bit     rq [2][$];
   longint tq [6][$];

   // Reference model: RUN once the synchronised lock has been seen high, with no
   // reset, for L+1 consecutive edges; ticks follow from the RUN-cycle index.
   bit     rst_h1 = 1'b0, rst_h2 = 1'b0, lock_h1 = 1'b0, lock_h2 = 1'b0;
   longint streak [2] = '{0, 0};
   longint runk   [2] = '{0, 0};

   always @(posedge clk) begin
      bit ls, mrdy;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         ls = (d == 1) ? 1'b1 : (!rst_h1 && !rst_h2 && lock_h2);
         streak[d] = (ls && !rst) ? streak[d] + 1 : 0;
         mrdy = (streak[d] >= L + 1);
         runk[d] = mrdy ? runk[d] + 1 : 0;
         rq[d].push_back(mrdy);
         if (mrdy) begin
            if ((runk[d] * INC) / F != ((runk[d] - 1) * INC) / F) tq[d*3+0].push_back(cyc);
            if (runk[d] % SPI_DIV == 0) tq[d*3+1].push_back(cyc);
            if (runk[d] % MS_DIV == 0)  tq[d*3+2].push_back(cyc);
         end
      end
      rst_h2  = rst_h1;  rst_h1  = rst;
      lock_h2 = lock_h1; lock_h1 = lock;
   end

   longint runc = 0, n_uart = 0, n_spi = 0, n_ms = 0, last_uart = 0;
   bit     have_last = 1'b0;

   always @(posedge clk) begin
      bit     er, act, exp_now;
      int     idx;
      longint gap;
      req_t   r;
      #1;
      while (cq.size() > 0) begin
         r = cq.pop_front();
         checks++;
         if (r.act != r.exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", r.nm, r.act, r.exp, cyc);
         end
      end
      for (int d = 0; d < 2; d++) begin
         if (rq[d].size() > 0) begin
            er = rq[d].pop_front();
            checks++;
            if (ov[d][4] !== er || ov[d][3] !== !er) begin
               failures++;
               $display("FAIL ready dut%0d cycle %0d: ready=%b periph_rst=%b expected ready=%b periph_rst=%b",
                        d, cyc, ov[d][4], ov[d][3], er, !er);
            end
         end
         for (int t = 0; t < 3; t++) begin
            idx = d * 3 + t;
            act = (ov[d][2-t] !== 1'b0);
            while (tq[idx].size() > 0 && tq[idx][0] < cyc) begin
               checks++;
               failures++;
               $display("FAIL tick%0d dut%0d: missing at cycle %0d", t, d, tq[idx][0]);
               void'(tq[idx].pop_front());
            end
            exp_now = (tq[idx].size() > 0 && tq[idx][0] == cyc);
            if (act || exp_now) begin
               checks++;
               if (!(ov[d][2-t] === 1'b1 && exp_now)) begin
                  failures++;
                  $display("FAIL tick%0d dut%0d cycle %0d: got %b expected %b", t, d, cyc, ov[d][2-t], exp_now);
               end
               if (exp_now) void'(tq[idx].pop_front());
            end
         end
      end
      if (rdy_a === 1'b1) begin
         runc++;
         if (uart_a === 1'b1) begin
            n_uart++;
            if (have_last) begin
               gap = cyc - last_uart;
               checks++;
               if (gap != GAP_LO && gap != GAP_HI) begin
                  failures++;
                  $display("FAIL uart_gap: got %0d expected %0d or %0d", gap, GAP_LO, GAP_HI);
               end
            end
            have_last = 1'b1;
            last_uart = cyc;
         end
         if (spi_a === 1'b1) n_spi++;
         if (ms_a === 1'b1)  n_ms++;
      end else begin
         runc = 0; n_uart = 0; n_spi = 0; n_ms = 0; have_last = 1'b0;
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      req_t r;
      r.nm = nm; r.act = act; r.exp = exp;
      cq.push_back(r);
   endtask

   task automatic edges_until(input int which, input bit val, input int budget, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (((which == 0) ? rdy_a : rdy_b) !== val && n <= budget);
   endtask

   initial begin
      int n, k, k_spi, k_uart, dur;
      rst  = 1'b1;
      lock = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_ready", longint'(rdy_a === 1'b1), 0);
      chk("reset_periph_rst", longint'(prst_a === 1'b1), 1);
      chk("reset_ticks", longint'({uart_a, spi_a, ms_a, uart_b, spi_b, ms_b} !== '0), 0);

      // Release with lock low: A must wait, B (lock ignored) starts counting.
      rst = 1'b0;
      edges_until(1, 1'b1, 1200, n);
      chk("b_ready_latency", n, L + 1);
      repeat (100) @(negedge clk);
      chk("a_stays_wait_lock", longint'(rdy_a === 1'b1), 0);

      lock = 1'b1;
      edges_until(0, 1'b1, 1200, n);
      chk("a_ready_latency", n, 2 + L + 1);
      chk("a_periph_rst_low", longint'(prst_a === 1'b1), 0);

      n = 0;
      while (runc < 6600 && n < 8000) begin
         @(negedge clk);
         n++;
      end
      chk("run_window_cycles", runc, 6600);
      chk("run_window_uart", n_uart, 184);
      chk("run_window_spi", n_spi, 200);
      chk("run_window_ms", n_ms, 10);

      @(negedge clk) lock = 1'b0;
      edges_until(0, 1'b0, 10, n);
      chk("lock_drop_latency", n, 3);

      repeat (5) @(negedge clk);
      lock = 1'b1;
      repeat (503) @(negedge clk);
      lock = 1'b0;
      @(negedge clk) lock = 1'b1;
      edges_until(0, 1'b1, 1200, n);
      chk("glitch_recount_latency", n, 2 + L + 1);

      repeat ($urandom_range(10, 200)) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("run_reset_ready", longint'(rdy_a === 1'b1), 0);
      chk("run_reset_periph_rst", longint'(prst_a === 1'b1), 1);
      @(negedge clk) rst = 1'b0;
      edges_until(0, 1'b1, 1200, n);
      k = 1; k_spi = 0; k_uart = 0;
      while ((k_spi == 0 || k_uart == 0) && k < 100) begin
         if (k_spi == 0 && spi_a === 1'b1)   k_spi = k;
         if (k_uart == 0 && uart_a === 1'b1) k_uart = k;
         if (k_spi == 0 || k_uart == 0) begin
            @(posedge clk); #1;
            k++;
         end
      end
      chk("spi_first_after_reentry", k_spi, SPI_DIV);
      chk("uart_first_after_reentry", k_uart, (F + INC - 1) / INC);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lock = ($urandom_range(0, 3) != 0);
         dur  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 1300);
         if ($urandom_range(0, 7) == 0) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b0;
         end
         repeat (dur) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
